// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state codes, default vector layout,
// and the vector address helper.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        INT_IDLE    = 2'd0,
        INT_TAKE    = 2'd1,
        INT_HANDLER = 2'd2,
        INT_RETURN  = 2'd3
    } int_state_e;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
    localparam int unsigned DEF_VEC_STRIDE = 4;

    // Vector address wraps modulo 2^32; the source index is zero-extended.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [2:0]  idx,
                                             input int unsigned stride);
        logic [31:0] w_off;
        w_off = {29'd0, idx} * stride;
        return base + w_off;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: lowest set request bit wins.
module int_prio_enc #(
    parameter int unsigned N_SRC = 4
) (
    input  logic [N_SRC-1:0] i_req,
    output logic             o_valid,
    output logic [2:0]       o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = 3'd0;
        // Walk from the top so the lowest set index is the last assignment.
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detected pending requests, priority pick, and one-cycle
// redirects to the vector on entry and back to the saved PC on eret.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_irq_in,
    input  logic             i_int_en,
    input  logic [N_SRC-1:0] i_irq_mask,
    input  logic             i_can_take,
    input  logic [31:0]      i_cur_pc,
    input  logic             i_eret,
    output logic             o_int_sig,
    output logic [31:0]      o_int_addr,
    output logic [31:0]      o_epc,
    output logic [2:0]       o_cause,
    output logic             o_in_handler,
    output logic [N_SRC-1:0] o_pending
);

    int_state_e       r_state;
    int_state_e       w_state_nxt;
    logic [N_SRC-1:0] r_irq_prev;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] w_pending_nxt;
    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_clr;
    logic [31:0]      r_epc;
    logic [2:0]       r_cause;
    logic             w_win_valid;
    logic [2:0]       w_win_idx;

    assign w_edge     = i_irq_in & ~r_irq_prev;
    assign w_eligible = r_pending & ~i_irq_mask;

    int_prio_enc #(
        .N_SRC(N_SRC)
    ) u_prio_enc (
        .i_req  (w_eligible),
        .o_valid(w_win_valid),
        .o_idx  (w_win_idx)
    );

    // Clear is applied before the new edge so a same-cycle edge keeps the bit set.
    always_comb begin
        w_clr = '0;
        if (r_state == INT_TAKE) begin
            w_clr = N_SRC'(1) << r_cause;
        end
        w_pending_nxt = (r_pending & ~w_clr) | w_edge;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            INT_IDLE: begin
                if (i_int_en && w_win_valid && i_can_take) begin
                    w_state_nxt = INT_TAKE;
                end
            end
            INT_TAKE:    w_state_nxt = INT_HANDLER;
            INT_HANDLER: begin
                if (i_eret) begin
                    w_state_nxt = INT_RETURN;
                end
            end
            INT_RETURN:  w_state_nxt = INT_IDLE;
            default:     w_state_nxt = INT_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= INT_IDLE;
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_epc      <= 32'd0;
            r_cause    <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_irq_prev <= i_irq_in;
            r_pending  <= w_pending_nxt;
            if (r_state == INT_IDLE && w_state_nxt == INT_TAKE) begin
                r_cause <= w_win_idx;
            end
            if (r_state == INT_TAKE) begin
                r_epc <= i_cur_pc;
            end
        end
    end

    always_comb begin
        o_int_sig  = 1'b0;
        o_int_addr = 32'd0;
        unique case (r_state)
            INT_TAKE: begin
                o_int_sig  = 1'b1;
                o_int_addr = vec_addr(VEC_BASE, r_cause, VEC_STRIDE);
            end
            INT_RETURN: begin
                o_int_sig  = 1'b1;
                o_int_addr = r_epc;
            end
            default: begin
                o_int_sig  = 1'b0;
                o_int_addr = 32'd0;
            end
        endcase
    end

    assign o_in_handler = (r_state != INT_IDLE);
    assign o_epc        = r_epc;
    assign o_cause      = r_cause;
    assign o_pending    = r_pending;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl with hand-computed expectations.
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_in;
    logic        int_en;
    logic [3:0]  irq_mask;
    logic        can_take;
    logic [31:0] cur_pc;
    logic        eret;
    logic        int_sig;
    logic [31:0] int_addr;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        in_handler;
    logic [3:0]  pending;

    int n_checks = 0;
    int n_errors = 0;

    int_ctrl #(
        .N_SRC     (4),
        .VEC_BASE  (32'h0000_0100),
        .VEC_STRIDE(4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_irq_in    (irq_in),
        .i_int_en    (int_en),
        .i_irq_mask  (irq_mask),
        .i_can_take  (can_take),
        .i_cur_pc    (cur_pc),
        .i_eret      (eret),
        .o_int_sig   (int_sig),
        .o_int_addr  (int_addr),
        .o_epc       (epc),
        .o_cause     (cause),
        .o_in_handler(in_handler),
        .o_pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = 4'b0; int_en = 1'b1; irq_mask = 4'b0;
        can_take = 1'b1; cur_pc = 32'd0; eret = 1'b0;
        #1;
        n_checks++;
        if (int_sig !== 1'b0 || int_addr !== 32'd0 || in_handler !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: int_sig=%b int_addr=%h in_handler=%b, want 0/0/0",
                     int_sig, int_addr, in_handler);
        end
        n_checks++;
        if (pending !== 4'b0 || epc !== 32'd0 || cause !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_regs: pending=%b epc=%h cause=%0d, want 0/0/0",
                     pending, epc, cause);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (int_sig !== 1'b0 || in_handler !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: int_sig=%b in_handler=%b, want 0/0", int_sig, in_handler);
        end
    endtask

    task automatic test_basic();
        cur_pc = 32'h40;
        irq_in = 4'b0100;
        tick();
        n_checks++;
        if (int_sig !== 1'b0 || pending !== 4'b0100) begin
            n_errors++;
            $display("FAIL basic_pend: int_sig=%b pending=%b, want 0/0100", int_sig, pending);
        end
        tick();
        n_checks++;
        if (int_sig !== 1'b1 || int_addr !== 32'h108 || cause !== 3'd2 || in_handler !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_take: int_sig=%b addr=%h cause=%0d inh=%b, want 1/108/2/1",
                     int_sig, int_addr, cause, in_handler);
        end
        irq_in = 4'b0;
        tick();
        n_checks++;
        if (int_sig !== 1'b0 || epc !== 32'h40 || pending !== 4'b0 || int_addr !== 32'd0) begin
            n_errors++;
            $display("FAIL basic_handler: int_sig=%b epc=%h pending=%b addr=%h, want 0/40/0000/0",
                     int_sig, epc, pending, int_addr);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++;
        if (int_sig !== 1'b1 || int_addr !== 32'h40) begin
            n_errors++;
            $display("FAIL basic_return: int_sig=%b addr=%h, want 1/40", int_sig, int_addr);
        end
        tick();
        n_checks++;
        if (int_sig !== 1'b0 || in_handler !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_idle: int_sig=%b in_handler=%b, want 0/0", int_sig, in_handler);
        end
    endtask

    task automatic test_prio_mask();
        irq_mask = 4'b0010;
        cur_pc   = 32'h80;
        irq_in   = 4'b1010;
        tick();
        tick();
        n_checks++;
        if (int_sig !== 1'b1 || int_addr !== 32'h10C || cause !== 3'd3) begin
            n_errors++;
            $display("FAIL prio_take: int_sig=%b addr=%h cause=%0d, want 1/10c/3",
                     int_sig, int_addr, cause);
        end
        irq_in = 4'b0;
        tick();
        n_checks++;
        if (pending !== 4'b0010) begin
            n_errors++;
            $display("FAIL prio_pending: pending=%b, want 0010", pending);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        tick();
        n_checks++;
        if (int_sig !== 1'b0 || pending !== 4'b0010) begin
            n_errors++;
            $display("FAIL mask_hold: int_sig=%b pending=%b, want 0/0010", int_sig, pending);
        end
        irq_mask = 4'b0;
        tick();
        n_checks++;
        if (int_sig !== 1'b1 || int_addr !== 32'h104) begin
            n_errors++;
            $display("FAIL unmask_take: int_sig=%b addr=%h, want 1/104", int_sig, int_addr);
        end
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        can_take = 1'b0;
        cur_pc   = 32'h200;
        irq_in   = 4'b0001;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (int_sig !== 1'b0 || pending !== 4'b0001) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: int_sig=%b pending=%b, want 0/0001",
                         i, int_sig, pending);
            end
            tick();
        end
        can_take = 1'b1;
        tick();
        n_checks++;
        if (int_sig !== 1'b1 || int_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL stall_take: int_sig=%b addr=%h, want 1/100", int_sig, int_addr);
        end
        can_take = 1'b0;
        irq_in   = 4'b0;
        tick();
        n_checks++;
        if (in_handler !== 1'b1 || int_sig !== 1'b0 || epc !== 32'h200) begin
            n_errors++;
            $display("FAIL take_committed: inh=%b int_sig=%b epc=%h, want 1/0/200",
                     in_handler, int_sig, epc);
        end
        can_take = 1'b1;
    endtask

    task automatic test_nesting();
        irq_in = 4'b0001;
        tick();
        n_checks++;
        if (int_sig !== 1'b0 || pending !== 4'b0001 || in_handler !== 1'b1) begin
            n_errors++;
            $display("FAIL nest_pend: int_sig=%b pending=%b inh=%b, want 0/0001/1",
                     int_sig, pending, in_handler);
        end
        irq_in = 4'b0;
        tick();
        n_checks++;
        if (int_sig !== 1'b0) begin
            n_errors++;
            $display("FAIL nest_no_redirect: int_sig=%b, want 0", int_sig);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++;
        if (int_sig !== 1'b1 || int_addr !== 32'h200) begin
            n_errors++;
            $display("FAIL nest_return: int_sig=%b addr=%h, want 1/200", int_sig, int_addr);
        end
        tick();
        n_checks++;
        if (int_sig !== 1'b0 || in_handler !== 1'b0) begin
            n_errors++;
            $display("FAIL nest_idle: int_sig=%b inh=%b, want 0/0", int_sig, in_handler);
        end
        tick();
        n_checks++;
        if (int_sig !== 1'b1 || int_addr !== 32'h100 || cause !== 3'd0) begin
            n_errors++;
            $display("FAIL back_to_back: int_sig=%b addr=%h cause=%0d, want 1/100/0",
                     int_sig, int_addr, cause);
        end
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    task automatic test_eret_idle_same_edge();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++;
        if (int_sig !== 1'b0 || in_handler !== 1'b0) begin
            n_errors++;
            $display("FAIL eret_idle: int_sig=%b inh=%b, want 0/0", int_sig, in_handler);
        end
        irq_in = 4'b0100;
        tick();
        irq_in = 4'b0;
        tick();
        n_checks++;
        if (int_sig !== 1'b1 || int_addr !== 32'h108) begin
            n_errors++;
            $display("FAIL edge_take: int_sig=%b addr=%h, want 1/108", int_sig, int_addr);
        end
        irq_in = 4'b0100;
        tick();
        n_checks++;
        if (pending !== 4'b0100 || in_handler !== 1'b1) begin
            n_errors++;
            $display("FAIL edge_in_take: pending=%b inh=%b, want 0100/1", pending, in_handler);
        end
        irq_in = 4'b0;
        eret   = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        tick();
        n_checks++;
        if (int_sig !== 1'b1 || int_addr !== 32'h108) begin
            n_errors++;
            $display("FAIL edge_retake: int_sig=%b addr=%h, want 1/108", int_sig, int_addr);
        end
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        cur_pc = 32'h300;
        irq_in = 4'b0001;
        tick();
        tick();
        irq_in = 4'b0;
        tick();
        irq_in = 4'b0110;
        tick();
        n_checks++;
        if (in_handler !== 1'b1 || pending !== 4'b0110 || epc !== 32'h300) begin
            n_errors++;
            $display("FAIL pre_reset: inh=%b pending=%b epc=%h, want 1/0110/300",
                     in_handler, pending, epc);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (int_sig !== 1'b0 || in_handler !== 1'b0 || pending !== 4'b0 || epc !== 32'd0) begin
            n_errors++;
            $display("FAIL async_reset: int_sig=%b inh=%b pending=%b epc=%h, want 0/0/0000/0",
                     int_sig, in_handler, pending, epc);
        end
        irq_in = 4'b0;
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (int_sig !== 1'b0 || pending !== 4'b0 || cause !== 3'd0) begin
            n_errors++;
            $display("FAIL post_reset: int_sig=%b pending=%b cause=%0d, want 0/0000/0",
                     int_sig, pending, cause);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prio_mask();
        test_stall();
        test_nesting();
        test_eret_idle_same_edge();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
